b12_autoplayer: RTL and testbench

Synchronous automatic player for the b12 memory game. It sits on the opposite side of the game's key/LED interface. It watches the game's `nl` LEDs and `nloss` lamp, memorises each colour the game plays back, and replays the sequence on the `k` key lines, one key per LED acknowledge. It is used as a closed-loop stimulus and opponent when the b12 game is checked in simulation and by formal tools.

---
 rtl/b12_pkg.sv | 55 +++++
 rtl/b12_seq_store.sv | 22 ++
 rtl/b12_autoplayer.sv | 183 ++++++++++++++++++
 tb/tb_b12_autoplayer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/b12_pkg.sv
// Shared definitions for the b12 game and its automatic player:
// state encoding, LED/key polarity and colour helpers.
package b12_pkg;

  localparam int unsigned MAX_ROUNDS = 32;
  localparam int unsigned NCOLOURS   = 4;
  localparam int unsigned COLOUR_W   = 2;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned ROUND_W    = 6;
  localparam int unsigned CNT_W      = 8;

  localparam logic LED_ON = 1'b1;
  localparam logic KEY_ON = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_PW_ON,
    S_PW_OFF,
    S_R_PRESS,
    S_R_REL,
    S_W_END,
    S_WON,
    S_LOST,
    S_TIMEOUT
  } state_t;

  // Registered view of the game's lamps.
  typedef struct packed {
    logic [NCOLOURS-1:0] nl;
    logic                nloss;
  } game_in_t;

  function automatic logic [NCOLOURS-1:0] colour_onehot(input logic [COLOUR_W-1:0] c);
    logic [NCOLOURS-1:0] oh;
    oh    = '0;
    oh[c] = KEY_ON;
    return oh;
  endfunction

  // Lowest lit LED wins; the game never lights more than one during playback.
  function automatic logic [COLOUR_W-1:0] led_colour(input logic [NCOLOURS-1:0] leds);
    logic [COLOUR_W-1:0] c;
    c = '0;
    for (int i = NCOLOURS - 1; i >= 0; i--) begin
      if (leds[i] == LED_ON) c = COLOUR_W'(i);
    end
    return c;
  endfunction

  function automatic logic is_busy(input state_t s);
    return !(s inside {S_IDLE, S_WON, S_LOST, S_TIMEOUT});
  endfunction

endpackage

// File: rtl/b12_seq_store.sv
// Colour sequence memory: 32 x 2-bit register file, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module b12_seq_store
  import b12_pkg::*;
(
  input  logic                clock,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [COLOUR_W-1:0] wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [COLOUR_W-1:0] rdata_c
);

  logic [COLOUR_W-1:0] mem [MAX_ROUNDS];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/b12_autoplayer.sv
// Automatic opponent for the b12 memory game: memorises each colour the game
// plays back on nl and replays the sequence on k, one key per LED echo.
module b12_autoplayer #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_ROUNDS = b12_pkg::MAX_ROUNDS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       inject_err,
  input  logic [3:0] nl,
  input  logic       nloss,
  output logic       start,
  output logic [3:0] k,
  output logic       busy,
  output logic       won,
  output logic       lost,
  output logic       stall,
  output logic [5:0] round
);

  import b12_pkg::*;

  state_t                state, state_n;
  game_in_t              in_q, in_prev;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [ROUND_W-1:0]    round_n;
  logic [CNT_W-1:0]      idle_cnt, idle_cnt_n;
  logic [NCOLOURS-1:0]   k_n;
  logic                  start_n, busy_n, won_n, lost_n, stall_n;

  logic                  mem_we_c;
  logic [COLOUR_W-1:0]   colour_c;
  logic [IDX_W-1:0]      raddr_c;
  logic [COLOUR_W-1:0]   rdata_c;
  logic [NCOLOURS-1:0]   key_c;

  assign colour_c = led_colour(in_q.nl);

  b12_seq_store u_store (
    .clock   (clock),
    .we      (mem_we_c),
    .waddr   (idx),
    .wdata   (colour_c),
    .raddr   (raddr_c),
    .rdata_c (rdata_c)
  );

  // Read the element the next press will use, so k appears on R_PRESS entry.
  always_comb begin
    raddr_c = idx;
    if (state == S_PW_OFF)     raddr_c = '0;
    else if (state == S_R_REL) raddr_c = idx + IDX_W'(1);
  end

  assign key_c = colour_onehot(COLOUR_W'(rdata_c + COLOUR_W'(inject_err)));

  // Next-state and registered-output logic.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    round_n    = round;
    k_n        = k;
    start_n    = 1'b0;
    won_n      = won;
    lost_n     = lost;
    stall_n    = stall;
    mem_we_c   = 1'b0;
    idle_cnt_n = idle_cnt;

    if (in_q != in_prev)                   idle_cnt_n = '0;
    else if (idle_cnt != CNT_W'(TIMEOUT))  idle_cnt_n = idle_cnt + CNT_W'(1);

    case (state)
      S_IDLE: begin
        if (go) begin
          state_n    = S_START;
          start_n    = 1'b1;
          idx_n      = '0;
          round_n    = '0;
          won_n      = 1'b0;
          lost_n     = 1'b0;
          stall_n    = 1'b0;
          idle_cnt_n = '0;
        end
      end
      S_START: begin
        state_n = S_PW_ON;
      end
      S_PW_ON: begin
        if (in_q.nl != '0) begin
          mem_we_c = 1'b1;
          state_n  = S_PW_OFF;
        end
      end
      S_PW_OFF: begin
        if (in_q.nl == '0) begin
          if (idx == round[IDX_W-1:0]) begin
            idx_n   = '0;
            k_n     = key_c;
            state_n = S_R_PRESS;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = S_PW_ON;
          end
        end
      end
      S_R_PRESS: begin
        if (in_q.nl != '0) begin
          k_n     = '0;
          state_n = S_R_REL;
        end
      end
      S_R_REL: begin
        if (in_q.nl == '0) begin
          if (idx == round[IDX_W-1:0]) begin
            idx_n   = '0;
            round_n = round + ROUND_W'(1);
            state_n = (round_n == ROUND_W'(MAX_ROUNDS)) ? S_W_END : S_PW_ON;
          end else begin
            idx_n   = idx + IDX_W'(1);
            k_n     = key_c;
            state_n = S_R_PRESS;
          end
        end
      end
      S_W_END, S_WON, S_LOST, S_TIMEOUT: begin
        state_n = state;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Loss, then win, then stall pre-empt any normal transition.
    if (is_busy(state)) begin
      if (in_q.nloss) begin
        state_n = S_LOST;
        lost_n  = 1'b1;
      end else if (in_q.nl == {NCOLOURS{LED_ON}}) begin
        state_n = S_WON;
        won_n   = 1'b1;
      end else if (idle_cnt == CNT_W'(TIMEOUT)) begin
        state_n = S_TIMEOUT;
        stall_n = 1'b1;
      end
    end

    if (state_n inside {S_WON, S_LOST, S_TIMEOUT}) k_n = '0;
    busy_n = is_busy(state_n);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      in_q     <= '0;
      in_prev  <= '0;
      idx      <= '0;
      round    <= '0;
      idle_cnt <= '0;
      k        <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      won      <= 1'b0;
      lost     <= 1'b0;
      stall    <= 1'b0;
    end else begin
      state    <= state_n;
      in_q     <= '{nl: nl, nloss: nloss};
      in_prev  <= in_q;
      idx      <= idx_n;
      round    <= round_n;
      idle_cnt <= idle_cnt_n;
      k        <= k_n;
      start    <= start_n;
      busy     <= busy_n;
      won      <= won_n;
      lost     <= lost_n;
      stall    <= stall_n;
    end
  end

endmodule

// File: tb/tb_b12_autoplayer.sv
// Bench for b12_autoplayer: a cycle-by-cycle vector table for the opening
// rounds and priority cases, then a behavioural game for the long sequences.
module tb_b12_autoplayer;

  localparam int unsigned TO = 255;
  localparam int unsigned NR = 32;

  logic       clock = 1'b0;
  logic       reset, go, inject_err, nloss;
  logic [3:0] nl;
  logic       start, busy, won, lost, stall;
  logic [3:0] k;
  logic [5:0] round;

  int checks = 0;
  int errors = 0;
  int multihot = 0;
  logic [1:0] col [NR];

  b12_autoplayer #(.TIMEOUT(TO), .MAX_ROUNDS(NR)) dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .inject_err (inject_err),
    .nl         (nl),
    .nloss      (nloss),
    .start      (start),
    .k          (k),
    .busy       (busy),
    .won        (won),
    .lost       (lost),
    .stall      (stall),
    .round      (round)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if ($countones(k) > 1) multihot++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic       rst;
    logic       g;
    logic [3:0] n;
    logic       nls;
    logic       s, b, w, l, st;
    logic [3:0] kk;
    logic [5:0] r;
  } vec_t;

  function automatic vec_t mk(input logic rst_i, input logic g_i, input logic [3:0] n_i,
                              input logic nls_i, input logic s_i, input logic b_i,
                              input logic w_i, input logic l_i, input logic st_i,
                              input logic [3:0] k_i, input logic [5:0] r_i);
    vec_t v;
    v = '{rst: rst_i, g: g_i, n: n_i, nls: nls_i, s: s_i, b: b_i, w: w_i, l: l_i,
          st: st_i, kk: k_i, r: r_i};
    return v;
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; nl = '0; nloss = 1'b0; inject_err = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_k(output logic [3:0] got);
    int n = 0;
    while (k == 4'b0 && n < 40) begin
      tick();
      n++;
    end
    got = k;
  endtask

  // Plays rounds from PW_ON onwards; err_round marks the round whose first
  // press is corrupted, after which the game raises nloss and stops.
  task automatic run_game(input int err_round);
    logic [3:0] got;
    int n;
    for (int r = 0; r < int'(NR); r++) begin
      inject_err = (r == err_round);
      for (int j = 0; j <= r; j++) begin
        nl = oh(col[j]); tick(); tick(); tick();
        nl = '0;         tick(); tick(); tick();
      end
      for (int j = 0; j <= r; j++) begin
        wait_k(got);
        inject_err = 1'b0;
        if (r == err_round && j == 0) begin
          check("err_key", got, oh(2'(col[0] + 2'd1)));
          nloss = 1'b1;
          tick(); tick();
          check("err_lost", lost, 1);
          check("err_k", k, 0);
          check("err_round", round, 6'(err_round));
          check("err_won", won, 0);
          return;
        end
        check($sformatf("key_r%0d_p%0d", r, j), got, oh(col[j]));
        if (got == 4'b0) return;
        nl = got;
        n = 0;
        while (k != 4'b0 && n < 40) begin
          tick();
          n++;
        end
        tick();
        nl = '0;
        tick(); tick();
      end
    end
    nl = 4'hF;
    tick(); tick(); tick();
  endtask

  vec_t vecs [28];
  logic [3:0] got_k;
  int n_cyc;

  initial begin
    col[0] = 2'd2;
    col[1] = 2'd0;
    for (int i = 2; i < int'(NR); i++) col[i] = 2'((i * 3 + 1) % 4);

    //               rst go nl     nls  st bsy won lst stl k      round
    vecs[0]  = mk(1, 0, 4'h0, 0,   0, 0, 0, 0, 0, 4'h0, 0);
    vecs[1]  = mk(0, 0, 4'h0, 0,   0, 0, 0, 0, 0, 4'h0, 0);
    vecs[2]  = mk(0, 1, 4'h0, 0,   1, 1, 0, 0, 0, 4'h0, 0);
    vecs[3]  = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h0, 0);
    vecs[4]  = mk(0, 0, 4'h4, 0,   0, 1, 0, 0, 0, 4'h0, 0);
    vecs[5]  = mk(0, 0, 4'h4, 0,   0, 1, 0, 0, 0, 4'h0, 0);
    vecs[6]  = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h0, 0);
    vecs[7]  = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h4, 0);
    vecs[8]  = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h4, 0);
    vecs[9]  = mk(0, 0, 4'h4, 0,   0, 1, 0, 0, 0, 4'h4, 0);
    vecs[10] = mk(0, 0, 4'h4, 0,   0, 1, 0, 0, 0, 4'h0, 0);
    vecs[11] = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h0, 0);
    vecs[12] = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h0, 1);
    vecs[13] = mk(0, 0, 4'h4, 0,   0, 1, 0, 0, 0, 4'h0, 1);
    vecs[14] = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h0, 1);
    vecs[15] = mk(0, 0, 4'h1, 0,   0, 1, 0, 0, 0, 4'h0, 1);
    vecs[16] = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h0, 1);
    vecs[17] = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h4, 1);
    vecs[18] = mk(0, 0, 4'h4, 0,   0, 1, 0, 0, 0, 4'h4, 1);
    vecs[19] = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h0, 1);
    vecs[20] = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h1, 1);
    vecs[21] = mk(0, 0, 4'h1, 0,   0, 1, 0, 0, 0, 4'h1, 1);
    vecs[22] = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h0, 1);
    vecs[23] = mk(0, 0, 4'h0, 0,   0, 1, 0, 0, 0, 4'h0, 2);
    vecs[24] = mk(0, 0, 4'hF, 1,   0, 1, 0, 0, 0, 4'h0, 2);
    vecs[25] = mk(0, 0, 4'h0, 0,   0, 0, 0, 1, 0, 4'h0, 2);
    vecs[26] = mk(0, 1, 4'h0, 0,   0, 0, 0, 1, 0, 4'h0, 2);
    vecs[27] = mk(1, 0, 4'h0, 0,   0, 0, 0, 0, 0, 4'h0, 0);

    reset = 1'b1; go = 1'b0; nl = '0; nloss = 1'b0; inject_err = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(negedge clock);
      reset = vecs[i].rst; go = vecs[i].g; nl = vecs[i].n; nloss = vecs[i].nls;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d {start,busy,won,lost,stall,k,round}", i),
            {start, busy, won, lost, stall, k, round},
            {vecs[i].s, vecs[i].b, vecs[i].w, vecs[i].l, vecs[i].st, vecs[i].kk, vecs[i].r});
    end

    // Stall: inputs frozen from START entry.
    do_reset();
    go = 1'b1; tick(); go = 1'b0;
    check("to_start", start, 1);
    n_cyc = 0;
    while (!stall && n_cyc < int'(TO) + 20) begin
      tick();
      n_cyc++;
    end
    check("to_cycles", n_cyc, TO + 1);
    check("to_busy", busy, 0);
    check("to_k", k, 0);
    go = 1'b1; tick(); go = 1'b0; tick();
    check("to_go_ignored", {start, busy, stall}, 3'b001);

    // Reset while a key is held, then a clean full game to a win.
    do_reset();
    go = 1'b1; tick(); go = 1'b0;
    nl = oh(col[0]); tick(); tick(); tick();
    nl = '0;
    wait_k(got_k);
    check("rp_key", got_k, oh(col[0]));
    reset = 1'b1; tick(); reset = 1'b0;
    check("rp_after_reset", {k, busy, start}, 6'b0);
    go = 1'b1; tick(); go = 1'b0;
    check("rp_restart", {start, busy, round}, {1'b1, 1'b1, 6'd0});
    run_game(-1);
    check("win_won", won, 1);
    check("win_round", round, NR);
    check("win_lost", lost, 0);
    check("win_stall", stall, 0);
    check("win_busy", busy, 0);
    check("win_multihot", multihot, 0);

    // Corrupted press during round 3.
    do_reset();
    go = 1'b1; tick(); go = 1'b0;
    run_game(3);
    nloss = 1'b0;
    tick();
    check("err_lost_sticky", lost, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
